flag_hazard_ctrl: RTL and testbench

FLAG_HAZARD_CTRL -- requirements
Module: flag_hazard_ctrl

---
 rtl/flag_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_flag_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_hazard_ctrl.sv
// Condition-flag hazard controller: stages flag-setting results one cycle
// ahead of the flag register, detects B.cond hazards on pending flags, and
// resolves B.cond against committed or forwarded flags.
module flag_hazard_ctrl #(
  parameter int unsigned FWD_EN = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_setflags,
  input  logic [3:0]       ex_flags,
  input  logic             ex_flush,
  input  logic             pipe_stall,
  input  logic             id_valid,
  input  logic             id_bcond,
  input  logic [3:0]       id_cond,
  input  logic [3:0]       flag_q,
  output logic             SInstr,
  output logic [3:0]       flag_wdata,
  output logic             id_stall,
  output logic             br_valid,
  output logic             br_taken,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {StRun, StHold} state_e;

  localparam bit Fwd = (FWD_EN != 0);
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             mem_v_q, mem_v_d;
  logic [3:0]       mem_flags_q, mem_flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       ex_sets;
  logic       hazard;
  logic [3:0] eff;
  logic       cond_ok;

  // A flushed EX instruction never counts as a pending flag writer.
  assign ex_sets = ex_valid & ex_setflags & ~ex_flush;
  assign eff     = (Fwd && mem_v_q) ? mem_flags_q : flag_q;
  // AL/NV (14/15) ignore flags, so they never wait on a pending write.
  assign hazard  = id_valid & id_bcond & (id_cond < 4'd14) &
                   (ex_sets | (mem_v_q & ~Fwd));

  assign SInstr       = mem_v_q & ~pipe_stall;
  assign flag_wdata   = mem_flags_q;
  assign id_stall     = hazard;
  assign br_valid     = id_valid & id_bcond & ~hazard & ~pipe_stall;
  assign br_taken     = cond_ok;
  assign stall_cycles = cnt_q;

  // Evaluate the B.cond condition code on the effective {N,Z,V,C} flags.
  always_comb begin
    logic n, z, v, c;
    {n, z, v, c} = eff;
    cond_ok = 1'b1;
    case (id_cond)
      4'd0:    cond_ok = z;
      4'd1:    cond_ok = ~z;
      4'd2:    cond_ok = c;
      4'd3:    cond_ok = ~c;
      4'd4:    cond_ok = n;
      4'd5:    cond_ok = ~n;
      4'd6:    cond_ok = v;
      4'd7:    cond_ok = ~v;
      4'd8:    cond_ok = c & ~z;
      4'd9:    cond_ok = ~c | z;
      4'd10:   cond_ok = (n == v);
      4'd11:   cond_ok = (n != v);
      4'd12:   cond_ok = ~z & (n == v);
      4'd13:   cond_ok = z | (n != v);
      default: cond_ok = 1'b1;
    endcase
  end

  // Next state: everything holds while the pipeline is frozen.
  always_comb begin
    mem_v_d     = mem_v_q;
    mem_flags_d = mem_flags_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (!pipe_stall) begin
      mem_v_d     = ex_sets;
      mem_flags_d = ex_flags;
      unique case (state_q)
        StRun:   if (hazard) state_d = StHold;
        StHold:  if (!hazard) state_d = StRun;
        default: state_d = StRun;
      endcase
      if (hazard && (cnt_q != '1)) cnt_d = cnt_q + CntOne;
    end
  end

  // State registers; reset wins over the pipeline freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_v_q     <= 1'b0;
      mem_flags_q <= 4'b0000;
      state_q     <= StRun;
      cnt_q       <= '0;
    end else begin
      mem_v_q     <= mem_v_d;
      mem_flags_q <= mem_flags_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Directed bench for flag_hazard_ctrl: one stalling instance (FWD_EN=0) and
// one forwarding instance with a 2-bit counter to reach saturation quickly.
module tb_flag_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, ex_valid, ex_setflags, ex_flush, pipe_stall;
  logic       id_valid, id_bcond;
  logic [3:0] ex_flags, id_cond, flag_q;

  logic        sinstr0, stall0, brv0, brt0;
  logic [3:0]  wdata0;
  logic [15:0] cnt0;
  logic        sinstr1, stall1, brv1, brt1;
  logic [3:0]  wdata1;
  logic [1:0]  cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_hazard_ctrl #(.FWD_EN(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_setflags(ex_setflags),
    .ex_flags(ex_flags), .ex_flush(ex_flush), .pipe_stall(pipe_stall),
    .id_valid(id_valid), .id_bcond(id_bcond), .id_cond(id_cond), .flag_q(flag_q),
    .SInstr(sinstr0), .flag_wdata(wdata0), .id_stall(stall0), .br_valid(brv0),
    .br_taken(brt0), .stall_cycles(cnt0)
  );

  flag_hazard_ctrl #(.FWD_EN(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_setflags(ex_setflags),
    .ex_flags(ex_flags), .ex_flush(ex_flush), .pipe_stall(pipe_stall),
    .id_valid(id_valid), .id_bcond(id_bcond), .id_cond(id_cond), .flag_q(flag_q),
    .SInstr(sinstr1), .flag_wdata(wdata1), .id_stall(stall1), .br_valid(brv1),
    .br_taken(brt1), .stall_cycles(cnt1)
  );

  // Reference condition table on {N,Z,V,C}.
  function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_setflags = 0; ex_flags = 0; ex_flush = 0; pipe_stall = 0;
    id_valid = 0; id_bcond = 0; id_cond = 0; flag_q = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic set_ex_s(input logic [3:0] f);
    ex_valid = 1; ex_setflags = 1; ex_flags = f;
  endtask

  task automatic set_id_b(input logic [3:0] cc);
    id_valid = 1; id_bcond = 1; id_cond = cc;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (sinstr0 !== 1'b0) begin errors++; $display("FAIL rst_sinstr0 got %b want 0", sinstr0); end
    checks++; if (wdata0 !== 4'b0000) begin errors++; $display("FAIL rst_wdata0 got %b want 0000", wdata0); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL rst_stall0 got %b want 0", stall0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL rst_cnt0 got %0d want 0", cnt0); end
    checks++; if (sinstr1 !== 1'b0) begin errors++; $display("FAIL rst_sinstr1 got %b want 0", sinstr1); end
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL rst_cnt1 got %0d want 0", cnt1); end
    step();
  endtask

  // SUBS (Z=1) in EX, B.EQ in ID; flag_q modelled as the stalling DUT's register.
  task automatic test_stall_and_forward();
    do_reset();
    set_ex_s(4'b0100); set_id_b(4'd0); flag_q = 4'b0000;
    @(negedge clk);
    checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL st_c0_stall0 got %b want 1", stall0); end
    checks++; if (brv0 !== 1'b0) begin errors++; $display("FAIL st_c0_brv0 got %b want 0", brv0); end
    checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL st_c0_stall1 got %b want 1", stall1); end
    checks++; if (brv1 !== 1'b0) begin errors++; $display("FAIL st_c0_brv1 got %b want 0", brv1); end
    step();
    ex_valid = 0; ex_setflags = 0; ex_flags = 0;
    @(negedge clk);
    checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL st_c1_stall0 got %b want 1", stall0); end
    checks++; if (sinstr0 !== 1'b1) begin errors++; $display("FAIL st_c1_sinstr0 got %b want 1", sinstr0); end
    checks++; if (wdata0 !== 4'b0100) begin errors++; $display("FAIL st_c1_wdata0 got %b want 0100", wdata0); end
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL st_c1_stall1 got %b want 0", stall1); end
    checks++; if (brv1 !== 1'b1) begin errors++; $display("FAIL st_c1_brv1 got %b want 1", brv1); end
    checks++; if (brt1 !== 1'b1) begin errors++; $display("FAIL st_c1_brt1_fwd got %b want 1", brt1); end
    checks++; if (cnt1 !== 2'd1) begin errors++; $display("FAIL st_c1_cnt1 got %0d want 1", cnt1); end
    step();
    flag_q = 4'b0100;
    @(negedge clk);
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL st_c2_stall0 got %b want 0", stall0); end
    checks++; if (brv0 !== 1'b1) begin errors++; $display("FAIL st_c2_brv0 got %b want 1", brv0); end
    checks++; if (brt0 !== 1'b1) begin errors++; $display("FAIL st_c2_brt0 got %b want 1", brt0); end
    checks++; if (cnt0 !== 16'd2) begin errors++; $display("FAIL st_c2_cnt0 got %0d want 2", cnt0); end
    checks++; if (sinstr0 !== 1'b0) begin errors++; $display("FAIL st_c2_sinstr0 got %b want 0", sinstr0); end
    step();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    set_ex_s(4'b1111); ex_flush = 1; set_id_b(4'd1); flag_q = 4'b0000;
    @(negedge clk);
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL fl_stall0 got %b want 0", stall0); end
    checks++; if (brv0 !== 1'b1) begin errors++; $display("FAIL fl_brv0 got %b want 1", brv0); end
    checks++; if (brt0 !== 1'b1) begin errors++; $display("FAIL fl_brt0 got %b want 1", brt0); end
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL fl_stall1 got %b want 0", stall1); end
    step();
    ex_valid = 0; ex_setflags = 0; ex_flush = 0; ex_flags = 0;
    @(negedge clk);
    checks++; if (sinstr0 !== 1'b0) begin errors++; $display("FAIL fl_sinstr0 got %b want 0", sinstr0); end
    checks++; if (sinstr1 !== 1'b0) begin errors++; $display("FAIL fl_sinstr1 got %b want 0", sinstr1); end
    checks++; if (brt1 !== 1'b1) begin errors++; $display("FAIL fl_brt1 got %b want 1", brt1); end
    step();
    idle();
  endtask

  task automatic test_always();
    do_reset();
    set_ex_s(4'b0000); set_id_b(4'd14);
    @(negedge clk);
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL al_stall0 got %b want 0", stall0); end
    checks++; if (brv0 !== 1'b1) begin errors++; $display("FAIL al_brv0 got %b want 1", brv0); end
    checks++; if (brt0 !== 1'b1) begin errors++; $display("FAIL al_brt0 got %b want 1", brt0); end
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL al_stall1 got %b want 0", stall1); end
    step();
    id_cond = 4'd15;
    @(negedge clk);
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL nv_stall0 got %b want 0", stall0); end
    checks++; if (brt0 !== 1'b1) begin errors++; $display("FAIL nv_brt0 got %b want 1", brt0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL nv_cnt0 got %0d want 0", cnt0); end
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ex_s(4'b1001); set_id_b(4'd0);
    step();
    ex_valid = 0; ex_setflags = 0; ex_flags = 0; reset = 1;
    @(negedge clk);
    checks++; if (sinstr0 !== 1'b1) begin errors++; $display("FAIL rm_pre_sinstr0 got %b want 1", sinstr0); end
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL rm_pre_cnt0 got %0d want 1", cnt0); end
    step();
    reset = 0;
    @(negedge clk);
    checks++; if (sinstr0 !== 1'b0) begin errors++; $display("FAIL rm_sinstr0 got %b want 0", sinstr0); end
    checks++; if (sinstr1 !== 1'b0) begin errors++; $display("FAIL rm_sinstr1 got %b want 0", sinstr1); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL rm_cnt0 got %0d want 0", cnt0); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL rm_stall0 got %b want 0", stall0); end
    checks++; if (brv0 !== 1'b1) begin errors++; $display("FAIL rm_brv0 got %b want 1", brv0); end
    step();
    idle();
  endtask

  task automatic test_pipe_stall();
    do_reset();
    set_ex_s(4'b1010);
    step();
    set_ex_s(4'b0101); pipe_stall = 1; set_id_b(4'd0);
    @(negedge clk);
    checks++; if (sinstr0 !== 1'b0) begin errors++; $display("FAIL ps_sinstr0 got %b want 0", sinstr0); end
    checks++; if (brv0 !== 1'b0) begin errors++; $display("FAIL ps_brv0 got %b want 0", brv0); end
    checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL ps_stall0 got %b want 1", stall0); end
    checks++; if (sinstr1 !== 1'b0) begin errors++; $display("FAIL ps_sinstr1 got %b want 0", sinstr1); end
    step();
    pipe_stall = 0; set_ex_s(4'b0011); id_valid = 0; id_bcond = 0;
    @(negedge clk);
    checks++; if (sinstr0 !== 1'b1) begin errors++; $display("FAIL ps_hold_sinstr0 got %b want 1", sinstr0); end
    checks++; if (wdata0 !== 4'b1010) begin errors++; $display("FAIL ps_hold_wdata0 got %b want 1010", wdata0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL ps_hold_cnt0 got %0d want 0", cnt0); end
    step();
    pipe_stall = 1; reset = 1; ex_valid = 0; ex_setflags = 0; ex_flags = 0;
    step();
    pipe_stall = 0; reset = 0;
    @(negedge clk);
    checks++; if (sinstr0 !== 1'b0) begin errors++; $display("FAIL ps_rst_sinstr0 got %b want 0", sinstr0); end
    checks++; if (wdata0 !== 4'b0000) begin errors++; $display("FAIL ps_rst_wdata0 got %b want 0000", wdata0); end
    step();
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_ex_s(4'b0001);
    step();
    set_ex_s(4'b0010);
    @(negedge clk);
    checks++; if (sinstr0 !== 1'b1) begin errors++; $display("FAIL bb1_sinstr0 got %b want 1", sinstr0); end
    checks++; if (wdata0 !== 4'b0001) begin errors++; $display("FAIL bb1_wdata0 got %b want 0001", wdata0); end
    step();
    ex_valid = 0; ex_setflags = 0; ex_flags = 0;
    @(negedge clk);
    checks++; if (sinstr0 !== 1'b1) begin errors++; $display("FAIL bb2_sinstr0 got %b want 1", sinstr0); end
    checks++; if (wdata0 !== 4'b0010) begin errors++; $display("FAIL bb2_wdata0 got %b want 0010", wdata0); end
    step();
    @(negedge clk);
    checks++; if (sinstr0 !== 1'b0) begin errors++; $display("FAIL bb3_sinstr0 got %b want 0", sinstr0); end
    step();
    idle();
  endtask

  // Hazard held for five edges: 16-bit counter reads 5, 2-bit counter pins at 3.
  task automatic test_saturate();
    do_reset();
    set_ex_s(4'b0000); set_id_b(4'd0);
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    checks++; if (cnt0 !== 16'd5) begin errors++; $display("FAIL sat_cnt0 got %0d want 5", cnt0); end
    checks++; if (cnt1 !== 2'd3) begin errors++; $display("FAIL sat_cnt1 got %0d want 3", cnt1); end
    step();
    @(negedge clk);
    checks++; if (cnt1 !== 2'd3) begin errors++; $display("FAIL sat_hold_cnt1 got %0d want 3", cnt1); end
    step();
    idle();
  endtask

  task automatic test_cond_sweep();
    logic exp;
    do_reset();
    id_valid = 1; id_bcond = 1;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        id_cond = 4'(c);
        flag_q  = 4'(f);
        #1;
        exp = cond_ref(4'(c), 4'(f));
        checks++;
        if (brt0 !== exp || brv0 !== 1'b1) begin
          errors++;
          $display("FAIL sweep0 cond=%0d flags=%b got taken=%b valid=%b want taken=%b valid=1",
                   c, f[3:0], brt0, brv0, exp);
        end
        checks++;
        if (brt1 !== exp) begin
          errors++;
          $display("FAIL sweep1 cond=%0d flags=%b got %b want %b", c, f[3:0], brt1, exp);
        end
      end
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_stall_and_forward();
    test_flush();
    test_always();
    test_reset_mid();
    test_pipe_stall();
    test_back_to_back();
    test_saturate();
    test_cond_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
